// File: rtl/axi_quad_spi_responder_if.sv
// AXI4-Lite bus bundle for axi_quad_spi_responder.
// Carries the five AXI4-Lite channels (AW, W, B, AR, R) with 32-bit address
// and data. The slave modport is used by the responder, the master modport
// by whatever drives it (the CCSDS TX IP or a testbench).
interface axi_quad_spi_responder_if;
  logic [31:0] s00_axi_awaddr;
  logic [2:0]  s00_axi_awprot;
  logic        s00_axi_awvalid;
  logic        s00_axi_awready;
  logic [31:0] s00_axi_wdata;
  logic [3:0]  s00_axi_wstrb;
  logic        s00_axi_wvalid;
  logic        s00_axi_wready;
  logic [1:0]  s00_axi_bresp;
  logic        s00_axi_bvalid;
  logic        s00_axi_bready;
  logic [31:0] s00_axi_araddr;
  logic [2:0]  s00_axi_arprot;
  logic        s00_axi_arvalid;
  logic        s00_axi_arready;
  logic [31:0] s00_axi_rdata;
  logic [1:0]  s00_axi_rresp;
  logic        s00_axi_rvalid;
  logic        s00_axi_rready;

  modport slave (
    input  s00_axi_awaddr, s00_axi_awprot, s00_axi_awvalid,
    output s00_axi_awready,
    input  s00_axi_wdata, s00_axi_wstrb, s00_axi_wvalid,
    output s00_axi_wready,
    output s00_axi_bresp, s00_axi_bvalid,
    input  s00_axi_bready,
    input  s00_axi_araddr, s00_axi_arprot, s00_axi_arvalid,
    output s00_axi_arready,
    output s00_axi_rdata, s00_axi_rresp, s00_axi_rvalid,
    input  s00_axi_rready
  );

  modport master (
    output s00_axi_awaddr, s00_axi_awprot, s00_axi_awvalid,
    input  s00_axi_awready,
    output s00_axi_wdata, s00_axi_wstrb, s00_axi_wvalid,
    input  s00_axi_wready,
    input  s00_axi_bresp, s00_axi_bvalid,
    output s00_axi_bready,
    output s00_axi_araddr, s00_axi_arprot, s00_axi_arvalid,
    input  s00_axi_arready,
    input  s00_axi_rdata, s00_axi_rresp, s00_axi_rvalid,
    output s00_axi_rready
  );
endinterface

// File: rtl/axi_quad_spi_responder.sv
// axi_quad_spi_responder
// AXI4-Lite slave that emulates the Quad-SPI register subset used by the
// CCSDS TX IP (DGIER, IPISR, IPIER, SPICR, SPISR, SPIDTR, SPIDRR). Bytes from
// an SPI-slave deserializer land in an RX FIFO read through SPIDRR; SPIDTR
// writes go through a TX FIFO to an SPI-slave serializer.
//
// Ports
//   s00_axi_aclk    clock
//   s00_axi_areset  asynchronous active-high reset
//   s_axi           AXI4-Lite slave (awaddr/wdata/bresp/araddr/rdata ...)
//   rx_data_i       byte from the deserializer
//   rx_valid_i      one-cycle strobe qualifying rx_data_i
//   tx_data_o       head of the TX FIFO (0 when empty)
//   tx_valid_o      SPE set and TX FIFO non-empty
//   tx_ready_i      serializer takes the byte; pops the TX FIFO with tx_valid_o
//   irq_o           registered DGIER.GIE & |(IPISR & IPIER)
module axi_quad_spi_responder #(
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_WIDTH = 7
) (
  input  logic                           s00_axi_aclk,
  input  logic                           s00_axi_areset,
  axi_quad_spi_responder_if.slave        s_axi,
  input  logic [7:0]                     rx_data_i,
  input  logic                           rx_valid_i,
  output logic [7:0]                     tx_data_o,
  output logic                           tx_valid_o,
  input  logic                           tx_ready_i,
  output logic                           irq_o
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  localparam logic [ADDR_WIDTH-1:0] OFF_DGIER  = ADDR_WIDTH'(7'h1C);
  localparam logic [ADDR_WIDTH-1:0] OFF_IPISR  = ADDR_WIDTH'(7'h20);
  localparam logic [ADDR_WIDTH-1:0] OFF_IPIER  = ADDR_WIDTH'(7'h28);
  localparam logic [ADDR_WIDTH-1:0] OFF_SPICR  = ADDR_WIDTH'(7'h60);
  localparam logic [ADDR_WIDTH-1:0] OFF_SPISR  = ADDR_WIDTH'(7'h64);
  localparam logic [ADDR_WIDTH-1:0] OFF_SPIDTR = ADDR_WIDTH'(7'h68);
  localparam logic [ADDR_WIDTH-1:0] OFF_SPIDRR = ADDR_WIDTH'(7'h6C);

  typedef enum logic {WR_IDLE, WR_RESP} wr_state_t;
  typedef enum logic {RD_IDLE, RD_RESP} rd_state_t;

  wr_state_t wr_state, wr_state_n;
  rd_state_t rd_state, rd_state_n;

  logic                  wr_en, rd_en;
  logic                  awready, wready, bvalid, arready, rvalid;
  logic [ADDR_WIDTH-1:0] wr_addr, rd_addr;
  logic [31:0]           wdata;
  logic [31:0]           rd_mux, rdata_q;

  // Control/status registers
  logic gie;
  logic ier_ne, ier_ovr;
  logic isr_ne, isr_ovr;
  logic cr_spe, cr_b7, cr_b8;
  logic irq_q;

  // FIFOs
  logic [7:0]       rx_mem [FIFO_DEPTH];
  logic [7:0]       tx_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rx_wptr, rx_rptr, tx_wptr, tx_rptr;
  logic [CNT_W-1:0] rx_count, tx_count;
  logic             rx_empty, rx_full, tx_empty, tx_full;
  logic             rx_push, rx_pop, tx_push, tx_pop;
  logic             rx_flush, tx_flush;
  logic             wr_spicr, wr_ipisr;
  logic             isr_set_ne, isr_set_ovr;

  assign wr_addr = s_axi.s00_axi_awaddr[ADDR_WIDTH-1:0];
  assign rd_addr = s_axi.s00_axi_araddr[ADDR_WIDTH-1:0];
  assign wdata   = s_axi.s00_axi_wdata;

  // ---------------------------------------------------------------------------
  // Write channel: AW and W are only taken together; ready is a one-cycle pulse
  // on the accepting edge, then B is held until bready.
  // ---------------------------------------------------------------------------
  always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
    if (s00_axi_areset) wr_state <= WR_IDLE;
    else                wr_state <= wr_state_n;
  end

  always_comb begin
    wr_state_n = wr_state;
    wr_en      = 1'b0;
    awready    = 1'b0;
    wready     = 1'b0;
    bvalid     = 1'b0;
    case (wr_state)
      WR_IDLE: begin
        if (s_axi.s00_axi_awvalid && s_axi.s00_axi_wvalid && !s00_axi_areset) begin
          wr_en      = 1'b1;
          awready    = 1'b1;
          wready     = 1'b1;
          wr_state_n = WR_RESP;
        end
      end
      WR_RESP: begin
        bvalid = 1'b1;
        if (s_axi.s00_axi_bready) wr_state_n = WR_IDLE;
      end
      default: wr_state_n = WR_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Read channel: arready pulses on the accepting edge, rdata is captured there
  // and held with rvalid until rready.
  // ---------------------------------------------------------------------------
  always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
    if (s00_axi_areset) rd_state <= RD_IDLE;
    else                rd_state <= rd_state_n;
  end

  always_comb begin
    rd_state_n = rd_state;
    rd_en      = 1'b0;
    arready    = 1'b0;
    rvalid     = 1'b0;
    case (rd_state)
      RD_IDLE: begin
        if (s_axi.s00_axi_arvalid && !s00_axi_areset) begin
          rd_en      = 1'b1;
          arready    = 1'b1;
          rd_state_n = RD_RESP;
        end
      end
      RD_RESP: begin
        rvalid = 1'b1;
        if (s_axi.s00_axi_rready) rd_state_n = RD_IDLE;
      end
      default: rd_state_n = RD_IDLE;
    endcase
  end

  assign s_axi.s00_axi_awready = awready;
  assign s_axi.s00_axi_wready  = wready;
  assign s_axi.s00_axi_bvalid  = bvalid;
  assign s_axi.s00_axi_bresp   = 2'b00;
  assign s_axi.s00_axi_arready = arready;
  assign s_axi.s00_axi_rvalid  = rvalid;
  assign s_axi.s00_axi_rresp   = 2'b00;
  assign s_axi.s00_axi_rdata   = rdata_q;

  // ---------------------------------------------------------------------------
  // Read data mux and capture
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_mux = 32'h0;
    case (rd_addr)
      OFF_DGIER:  rd_mux = {gie, 31'h0};
      OFF_IPISR:  rd_mux = {23'h0, isr_ne, 3'h0, isr_ovr, 4'h0};
      OFF_IPIER:  rd_mux = {23'h0, ier_ne, 3'h0, ier_ovr, 4'h0};
      OFF_SPICR:  rd_mux = {23'h0, cr_b8, cr_b7, 5'h0, cr_spe, 1'b0};
      OFF_SPISR:  rd_mux = {28'h0, tx_full, tx_empty, rx_full, rx_empty};
      OFF_SPIDRR: rd_mux = rx_empty ? 32'h0 : {24'h0, rx_mem[rx_rptr]};
      default:    rd_mux = 32'h0;
    endcase
  end

  always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
    if (s00_axi_areset)  rdata_q <= 32'h0;
    else if (rd_en)      rdata_q <= rd_mux;
  end

  // ---------------------------------------------------------------------------
  // Configuration registers
  // ---------------------------------------------------------------------------
  assign wr_spicr = wr_en && (wr_addr == OFF_SPICR);
  assign wr_ipisr = wr_en && (wr_addr == OFF_IPISR);
  // FIFO reset bits are acted on at the write edge and never stored.
  assign rx_flush = wr_spicr && wdata[6];
  assign tx_flush = wr_spicr && wdata[5];

  always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
    if (s00_axi_areset) begin
      gie     <= 1'b0;
      ier_ne  <= 1'b0;
      ier_ovr <= 1'b0;
      cr_spe  <= 1'b0;
      cr_b7   <= 1'b1;
      cr_b8   <= 1'b1;
    end else if (wr_en) begin
      case (wr_addr)
        OFF_DGIER: gie <= wdata[31];
        OFF_IPIER: begin
          ier_ne  <= wdata[8];
          ier_ovr <= wdata[4];
        end
        OFF_SPICR: begin
          cr_spe <= wdata[1];
          cr_b7  <= wdata[7];
          cr_b8  <= wdata[8];
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // RX FIFO. Fullness is judged on the current count, so a pop on the same
  // edge never makes room for an incoming byte.
  // ---------------------------------------------------------------------------
  assign rx_empty = (rx_count == '0);
  assign rx_full  = (rx_count == DEPTH_C);
  assign rx_push  = rx_valid_i && cr_spe && !rx_full;
  assign rx_pop   = rd_en && (rd_addr == OFF_SPIDRR) && !rx_empty;

  always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
    if (s00_axi_areset) begin
      rx_wptr  <= '0;
      rx_rptr  <= '0;
      rx_count <= '0;
    end else if (rx_flush) begin
      rx_wptr  <= '0;
      rx_rptr  <= '0;
      rx_count <= '0;
    end else begin
      if (rx_push) rx_wptr <= rx_wptr + PTR_ONE;
      if (rx_pop)  rx_rptr <= rx_rptr + PTR_ONE;
      case ({rx_push, rx_pop})
        2'b10:   rx_count <= rx_count + CNT_ONE;
        2'b01:   rx_count <= rx_count - CNT_ONE;
        default: rx_count <= rx_count;
      endcase
    end
  end

  always_ff @(posedge s00_axi_aclk) begin
    if (rx_push) rx_mem[rx_wptr] <= rx_data_i;
  end

  // ---------------------------------------------------------------------------
  // TX FIFO
  // ---------------------------------------------------------------------------
  assign tx_empty   = (tx_count == '0);
  assign tx_full    = (tx_count == DEPTH_C);
  assign tx_push    = wr_en && (wr_addr == OFF_SPIDTR) && !tx_full;
  assign tx_valid_o = cr_spe && !tx_empty;
  assign tx_pop     = tx_valid_o && tx_ready_i;
  assign tx_data_o  = tx_empty ? 8'h00 : tx_mem[tx_rptr];

  always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
    if (s00_axi_areset) begin
      tx_wptr  <= '0;
      tx_rptr  <= '0;
      tx_count <= '0;
    end else if (tx_flush) begin
      tx_wptr  <= '0;
      tx_rptr  <= '0;
      tx_count <= '0;
    end else begin
      if (tx_push) tx_wptr <= tx_wptr + PTR_ONE;
      if (tx_pop)  tx_rptr <= tx_rptr + PTR_ONE;
      case ({tx_push, tx_pop})
        2'b10:   tx_count <= tx_count + CNT_ONE;
        2'b01:   tx_count <= tx_count - CNT_ONE;
        default: tx_count <= tx_count;
      endcase
    end
  end

  always_ff @(posedge s00_axi_aclk) begin
    if (tx_push) tx_mem[tx_wptr] <= wdata[7:0];
  end

  // ---------------------------------------------------------------------------
  // Interrupt status. A set event on the same edge as a W1C wins because the
  // set assignment comes last.
  // ---------------------------------------------------------------------------
  assign isr_set_ne  = rx_push && rx_empty && !rx_flush;
  assign isr_set_ovr = rx_valid_i && cr_spe && rx_full;

  always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
    if (s00_axi_areset) begin
      isr_ne  <= 1'b0;
      isr_ovr <= 1'b0;
    end else begin
      if (wr_ipisr && wdata[8]) isr_ne  <= 1'b0;
      if (wr_ipisr && wdata[4]) isr_ovr <= 1'b0;
      if (isr_set_ne)           isr_ne  <= 1'b1;
      if (isr_set_ovr)          isr_ovr <= 1'b1;
    end
  end

  always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
    if (s00_axi_areset) irq_q <= 1'b0;
    else                irq_q <= gie && ((isr_ne && ier_ne) || (isr_ovr && ier_ovr));
  end

  assign irq_o = irq_q;

  // Address bits above the decode window, prot, strobes and unused data bits
  // carry no meaning for this register file.
  logic unused_bits;
  assign unused_bits = ^{s_axi.s00_axi_awaddr[31:ADDR_WIDTH],
                         s_axi.s00_axi_araddr[31:ADDR_WIDTH],
                         s_axi.s00_axi_awprot, s_axi.s00_axi_arprot,
                         s_axi.s00_axi_wstrb, wdata[30:9]};

endmodule

// File: tb/tb_axi_quad_spi_responder.sv
// Testbench for axi_quad_spi_responder: directed AXI/RX/TX stimulus, a
// queue-based behavioural model compared against the DUT every cycle, and
// literal expectations for the key register reads.
module tb_axi_quad_spi_responder;
  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       irq;

  always #5 clk = ~clk;

  axi_quad_spi_responder_if bus ();

  axi_quad_spi_responder #(.FIFO_DEPTH(DEPTH), .ADDR_WIDTH(7)) dut (
    .s00_axi_aclk   (clk),
    .s00_axi_areset (rst),
    .s_axi          (bus),
    .rx_data_i      (rx_data),
    .rx_valid_i     (rx_valid),
    .tx_data_o      (tx_data),
    .tx_valid_o     (tx_valid),
    .tx_ready_i     (tx_ready),
    .irq_o          (irq)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_spe, m_b7, m_b8, m_gie, m_ier8, m_ier4, m_isr8, m_isr4;
  bit          m_irq, m_bvalid, m_rvalid;
  logic [31:0] m_rdata;
  logic [7:0]  rxq[$];
  logic [7:0]  txq[$];

  function automatic void model_reset();
    m_spe = 0; m_b7 = 1; m_b8 = 1; m_gie = 0;
    m_ier8 = 0; m_ier4 = 0; m_isr8 = 0; m_isr4 = 0;
    m_irq = 0; m_bvalid = 0; m_rvalid = 0; m_rdata = 32'h0;
    rxq.delete();
    txq.delete();
  endfunction

  function automatic logic [31:0] model_read(input logic [6:0] off);
    logic [31:0] v;
    v = 32'h0;
    case (off)
      7'h1C: v[31] = m_gie;
      7'h20: begin v[8] = m_isr8; v[4] = m_isr4; end
      7'h28: begin v[8] = m_ier8; v[4] = m_ier4; end
      7'h60: begin v[8] = m_b8; v[7] = m_b7; v[1] = m_spe; end
      7'h64: begin
        v[0] = (rxq.size() == 0);
        v[1] = (rxq.size() == DEPTH);
        v[2] = (txq.size() == 0);
        v[3] = (txq.size() == DEPTH);
      end
      7'h6C: if (rxq.size() != 0) v[7:0] = rxq[0];
      default: v = 32'h0;
    endcase
    return v;
  endfunction

  function automatic void model_step();
    bit wr_hs, rd_hs, irq_n, rx_full0, rx_empty0, tx_full0, tx_pop, spe0;
    bit set8, set4, clr8, clr4, rx_flush, tx_flush;
    logic [6:0]  woff, roff;
    logic [31:0] wd;
    wr_hs     = bus.s00_axi_awvalid && bus.s00_axi_wvalid && !m_bvalid;
    rd_hs     = bus.s00_axi_arvalid && !m_rvalid;
    irq_n     = m_gie && ((m_isr8 && m_ier8) || (m_isr4 && m_ier4));
    rx_full0  = (rxq.size() == DEPTH);
    rx_empty0 = (rxq.size() == 0);
    tx_full0  = (txq.size() == DEPTH);
    tx_pop    = m_spe && (txq.size() != 0) && tx_ready;
    spe0      = m_spe;
    woff      = bus.s00_axi_awaddr[6:0];
    roff      = bus.s00_axi_araddr[6:0];
    wd        = bus.s00_axi_wdata;
    set8 = 0; set4 = 0; clr8 = 0; clr4 = 0; rx_flush = 0; tx_flush = 0;

    if (m_rvalid && bus.s00_axi_rready) m_rvalid = 0;
    if (rd_hs) begin
      m_rdata  = model_read(roff);
      m_rvalid = 1;
      if (roff == 7'h6C && !rx_empty0) void'(rxq.pop_front());
    end
    if (m_bvalid && bus.s00_axi_bready) m_bvalid = 0;

    if (rx_valid && spe0) begin
      if (rx_full0) set4 = 1;
      else begin
        rxq.push_back(rx_data);
        if (rx_empty0) set8 = 1;
      end
    end
    if (tx_pop) void'(txq.pop_front());

    if (wr_hs) begin
      m_bvalid = 1;
      case (woff)
        7'h1C: m_gie = wd[31];
        7'h20: begin clr8 = wd[8]; clr4 = wd[4]; end
        7'h28: begin m_ier8 = wd[8]; m_ier4 = wd[4]; end
        7'h60: begin
          m_spe = wd[1]; m_b7 = wd[7]; m_b8 = wd[8];
          rx_flush = wd[6]; tx_flush = wd[5];
        end
        7'h68: if (!tx_full0) txq.push_back(wd[7:0]);
        default: ;
      endcase
    end
    if (rx_flush) begin rxq.delete(); set8 = 0; end
    if (tx_flush) txq.delete();
    if (clr8) m_isr8 = 0;
    if (clr4) m_isr4 = 0;
    if (set8) m_isr8 = 1;
    if (set4) m_isr4 = 1;
    m_irq = irq_n;
  endfunction

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else     model_step();
    end
  end

  // Per-cycle comparison against the model
  initial begin
    forever begin
      @(negedge clk);
      check("awready", bus.s00_axi_awready,
            bus.s00_axi_awvalid && bus.s00_axi_wvalid && !m_bvalid && !rst);
      check("wready", bus.s00_axi_wready,
            bus.s00_axi_awvalid && bus.s00_axi_wvalid && !m_bvalid && !rst);
      check("bvalid", bus.s00_axi_bvalid, m_bvalid);
      check("bresp", bus.s00_axi_bresp, 0);
      check("arready", bus.s00_axi_arready, bus.s00_axi_arvalid && !m_rvalid && !rst);
      check("rvalid", bus.s00_axi_rvalid, m_rvalid);
      check("rdata", bus.s00_axi_rdata, m_rdata);
      check("rresp", bus.s00_axi_rresp, 0);
      check("tx_valid", tx_valid, m_spe && (txq.size() != 0));
      check("tx_data", tx_data, (txq.size() != 0) ? txq[0] : 8'h00);
      check("irq", irq, m_irq);
    end
  end

  // ---------------- drivers ----------------
  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data);
    int t;
    @(posedge clk); #1;
    bus.s00_axi_awaddr  = addr;
    bus.s00_axi_wdata   = data;
    bus.s00_axi_awvalid = 1'b1;
    bus.s00_axi_wvalid  = 1'b1;
    t = 0;
    @(negedge clk);
    while (!bus.s00_axi_awready && t < 20) begin @(negedge clk); t++; end
    check("wr_handshake", bus.s00_axi_awready && bus.s00_axi_wready, 1);
    @(posedge clk); #1;
    bus.s00_axi_awvalid = 1'b0;
    bus.s00_axi_wvalid  = 1'b0;
    check("bvalid_next_cycle", bus.s00_axi_bvalid, 1);
    if (bus.s00_axi_bready) begin @(posedge clk); #1; end
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [31:0] data);
    int t;
    @(posedge clk); #1;
    bus.s00_axi_araddr  = addr;
    bus.s00_axi_arvalid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!bus.s00_axi_arready && t < 20) begin @(negedge clk); t++; end
    check("ar_handshake", bus.s00_axi_arready, 1);
    @(posedge clk); #1;
    bus.s00_axi_arvalid = 1'b0;
    check("rvalid_next_cycle", bus.s00_axi_rvalid, 1);
    data = bus.s00_axi_rdata;
    if (bus.s00_axi_rready) begin @(posedge clk); #1; end
  endtask

  task automatic rx_strobe(input logic [7:0] b);
    @(posedge clk); #1;
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    rst = 1'b1;
    rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b0;
    bus.s00_axi_awaddr = '0; bus.s00_axi_awprot = '0; bus.s00_axi_awvalid = 1'b0;
    bus.s00_axi_wdata  = '0; bus.s00_axi_wstrb  = 4'hF; bus.s00_axi_wvalid  = 1'b0;
    bus.s00_axi_bready = 1'b1;
    bus.s00_axi_araddr = '0; bus.s00_axi_arprot = '0; bus.s00_axi_arvalid = 1'b0;
    bus.s00_axi_rready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_rdata", bus.s00_axi_rdata, 0);
    check("reset_tx_valid", tx_valid, 0);
    check("reset_irq", irq, 0);
    rst = 1'b0;

    // Reset values
    axi_read(32'h60, d); check("rst_spicr", d, 32'h180);
    axi_read(32'h64, d); check("rst_spisr", d, 32'h5);
    axi_read(32'h28, d); check("rst_ipier", d, 32'h0);
    axi_read(32'h1C, d); check("rst_dgier", d, 32'h0);

    // SPICR write/readback, with B held while bready is low
    bus.s00_axi_bready = 1'b0;
    axi_write(32'h60, 32'h182);
    repeat (2) @(posedge clk);
    #1;
    check("bvalid_held", bus.s00_axi_bvalid, 1);
    bus.s00_axi_bready = 1'b1;
    @(posedge clk); #1;
    check("bvalid_released", bus.s00_axi_bvalid, 0);
    axi_read(32'h60, d); check("spicr_rb", d, 32'h182);

    // Enable path and interrupt timing
    axi_write(32'h28, 32'h100);
    axi_write(32'h1C, 32'h8000_0000);
    rx_strobe(8'h4F);
    check("irq_n_plus_1", irq, 0);
    @(posedge clk); #1;
    check("irq_n_plus_2", irq, 1);
    axi_read(32'h64, d); check("spisr_rx1", d, 32'h4);
    axi_read(32'h6C, d); check("spidrr_4f", d, 32'h4F);
    axi_read(32'h64, d); check("spisr_drained", d, 32'h5);
    axi_write(32'h20, 32'h100);
    @(posedge clk); #1;
    check("irq_cleared", irq, 0);

    // TX path
    axi_write(32'h68, 32'h69);
    check("tx_valid_on", tx_valid, 1);
    check("tx_data_69", tx_data, 8'h69);
    axi_read(32'h64, d); check("spisr_tx1", d, 32'h1);
    @(posedge clk); #1; tx_ready = 1'b1;
    @(posedge clk); #1; tx_ready = 1'b0;
    check("tx_valid_off", tx_valid, 0);
    axi_read(32'h64, d); check("spisr_tx0", d, 32'h5);

    // Unmapped and write-only offsets
    axi_write(32'h40, 32'hFFFF_FFFF);
    axi_read(32'h40, d); check("unmapped", d, 32'h0);
    axi_read(32'h68, d); check("spidtr_read", d, 32'h0);

    // Overrun
    axi_write(32'h28, 32'h110);
    for (int i = 0; i < 17; i++) begin
      @(posedge clk); #1;
      rx_valid = 1'b1;
      rx_data  = 8'(i);
    end
    @(posedge clk); #1;
    rx_valid = 1'b0;
    axi_read(32'h64, d); check("spisr_full", d, 32'h6);
    axi_read(32'h20, d); check("ipisr_ovr", d, 32'h110);
    for (int i = 0; i < 16; i++) begin
      axi_read(32'h6C, d);
      check("drain", d, 32'(i));
    end
    axi_read(32'h6C, d); check("spidrr_empty", d, 32'h0);
    axi_read(32'h64, d); check("spisr_empty", d, 32'h5);
    axi_write(32'h20, 32'h110);
    axi_read(32'h20, d); check("ipisr_w1c", d, 32'h0);

    // Refill both FIFOs, then flush both with SPICR
    rx_strobe(8'hA1);
    rx_strobe(8'hA2);
    rx_strobe(8'hA3);
    axi_write(32'h68, 32'h11);
    axi_write(32'h68, 32'h22);
    axi_read(32'h64, d); check("spisr_both", d, 32'h0);
    axi_write(32'h60, 32'h1E2);
    axi_read(32'h64, d); check("spisr_flushed", d, 32'h5);
    axi_read(32'h60, d); check("spicr_selfclr", d, 32'h182);
    axi_read(32'h20, d); check("ipisr_kept", d, 32'h100);

    // Asynchronous reset while a read response is pending
    bus.s00_axi_rready = 1'b0;
    axi_read(32'h64, d);
    #2;
    rst = 1'b1;
    #1;
    check("rvalid_async_drop", bus.s00_axi_rvalid, 0);
    check("rdata_async_zero", bus.s00_axi_rdata, 0);
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.s00_axi_rready = 1'b1;
    axi_read(32'h64, d); check("spisr_after_rst", d, 32'h5);
    axi_read(32'h60, d); check("spicr_after_rst", d, 32'h180);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
